shift_add_mul: RTL and testbench



---
 rtl/shift_add_mul.sv | 95 +++++++++
 tb/tb_shift_add_mul.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mul
//  Brief    : Sequential unsigned shift-and-add multiplier. One partial
//             product is added per clock, so a run takes N iterations and
//             yields a 2N-bit product with a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   Ain,
  input  logic [N-1:0]   Bin,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [1:0]    c_IDLE = 2'd0;
  localparam logic [1:0]    c_RUN  = 2'd1;
  localparam logic [1:0]    c_DONE = 2'd2;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  logic [1:0]     r_state;
  logic [N-1:0]   r_m;     // multiplicand
  logic [N-1:0]   r_a;     // accumulator (high half of the running product)
  logic [N-1:0]   r_q;     // multiplier, shifted out as the low product fills in
  logic           r_c;     // adder carry-out; always cleared again by the shift
  logic [CW-1:0]  r_cnt;   // completed iterations
  logic [2*N-1:0] r_p;     // last completed product
  logic [N:0]     w_sum;   // {C,A} after this iteration's conditional add

  // Conditional partial-product add: accumulator plus multiplicand with
  // carry-in 0 when the current multiplier bit is set. r_c is zero whenever
  // RUN is active, so the pass-through branch equals {0,A}.
  always_comb begin
    w_sum = {r_c, r_a};
    if (r_q[0]) begin
      w_sum = {1'b0, r_a} + {1'b0, r_m};
    end
  end

  // Control FSM and datapath registers; reset discards any run in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_m     <= Ain;
            r_q     <= Bin;
            r_a     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          // Shift {C,A,Q} right by one using the post-add C and A.
          r_c   <= 1'b0;
          r_a   <= w_sum[N:1];
          r_q   <= {w_sum[0], r_q[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_p     <= {w_sum, r_q[N-1:1]};
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == c_RUN);
  assign done = (r_state == c_DONE);
  assign P    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mul
//  Brief    : Self-checking bench for shift_add_mul (N=8). Expected products
//             and completion cycles are queued when a start is driven and
//             checked when done is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul;

  localparam int N = 8;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc;   // cycle number of the accepting clock edge
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   Ain;
  logic [N-1:0]   Bin;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  int   busy_cnt;
  exp_t sb[$];

  shift_add_mul #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .Ain  (Ain),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .P    (P)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to time completions.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued run.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("product", 32'(P), 32'(e.prod));
        chk("latency", 32'(cyc - e.acc), 32'd8);
      end
    end
  end

  // One-cycle start pulse; the run is accepted at the next rising edge.
  task automatic mul(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    @(negedge clk);
    Ain   = a;
    Bin   = b;
    start = 1'b1;
    e.prod = 16'(a) * 16'(b);
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   lowc;
    logic hold_ok;
    exp_t e;
    total = 0; bad = 0; cyc = 0; done_cnt = 0; busy_cnt = 0;
    rst = 1'b1; start = 1'b0; Ain = '0; Bin = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_P", 32'(P), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 13*11: eight busy cycles, one done, then the product holds.
    busy_cnt = 0; done_cnt = 0;
    mul(8'd13, 8'd11);
    drain();
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("t1_done_cycles", 32'(done_cnt), 32'd1);
    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (P !== 16'h008F || busy !== 1'b0 || done !== 1'b0) hold_ok = 1'b0;
    end
    chk("t1_hold", 32'(hold_ok), 32'd1);

    // Carry path on every iteration, zero multiplicand, unit multiplicand.
    mul(8'd255, 8'd255); drain();
    mul(8'd0, 8'd200);   drain();
    mul(8'd1, 8'd255);   drain();

    // Requests during RUN and DONE are ignored; operand changes do not leak.
    done_cnt = 0;
    mul(8'd3, 8'd5);               // accepted at cycle c+1, leaves us at c+1
    @(negedge clk);                // c+2
    @(negedge clk);                // c+3
    Ain = 8'd7; Bin = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);     // c+9: DONE cycle
    chk("t4_in_done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_P", 32'(P), 32'd15);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset four iterations into a run; that run must vanish.
    done_cnt = 0;
    @(negedge clk);
    Ain = 8'd200; Bin = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_done_async", 32'(done), 32'd0);
    chk("t5_P_async", 32'(P), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    mul(8'd6, 8'd7); drain();
    chk("t5_P_after", 32'(P), 32'd42);

    // start held high: back-to-back runs every N+2 cycles.
    done_cnt = 0;
    @(negedge clk);
    Ain = 8'd10; Bin = 8'd10; start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      e.prod = 16'd100;
      e.acc  = cyc + 1;
      sb.push_back(e);
      lowc = 0;
      for (int k = 0; k < 10; k++) begin
        if (k != 0) @(negedge clk);
        if (!busy) lowc++;
      end
      @(negedge clk);
      chk("t6_busy_low", 32'(lowc), 32'd2);
    end
    start = 1'b0;
    drain();
    chk("t6_done_cnt", 32'(done_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
